// File: rtl/cfg_pkg.sv
`default_nettype none
// cfg_pkg: shared state encoding, block ids and record constants for the PE tile configuration loader.
package cfg_pkg;

   localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
   localparam logic [2:0] ST_ASSEMBLE_ENC = 3'd1;
   localparam logic [2:0] ST_ISSUE_ENC    = 3'd2;
   localparam logic [2:0] ST_GAP_ENC      = 3'd3;
   localparam logic [2:0] ST_DONE_ENC     = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = ST_IDLE_ENC,
      ST_ASSEMBLE = ST_ASSEMBLE_ENC,
      ST_ISSUE    = ST_ISSUE_ENC,
      ST_GAP      = ST_GAP_ENC,
      ST_DONE     = ST_DONE_ENC
   } state_t;

   localparam logic [15:0] BLK_COMPUTE = 16'd4;
   localparam logic [15:0] BLK_CB1     = 16'd5;
   localparam logic [15:0] BLK_CB0     = 16'd6;
   localparam logic [15:0] BLK_SB      = 16'd7;

   localparam logic [31:0] IDLE_ADDR_DEF = 32'hFFFF_FFFF;
   localparam logic [31:0] END_ADDR_DEF  = 32'hFFFF_FFFE;

   localparam int RECORD_BYTES = 8;

   function automatic logic [31:0] cfg_addr(input logic [15:0] block_id, input logic [15:0] tile_id);
      return {block_id, tile_id};
   endfunction

endpackage
`default_nettype wire

// File: rtl/config_record_assembler.sv
`default_nettype none
// config_record_assembler: collects bytes of one record; the final byte is forwarded
// combinationally so the loader can latch the complete record on the accepting edge.
module config_record_assembler
   import cfg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  in_data,
   output logic [31:0] rec_addr,
   output logic [31:0] rec_data,
   output logic        record_full
);

   localparam int              IDX_W    = $clog2(RECORD_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);

   logic [IDX_W-1:0]                idx;
   logic [8*(RECORD_BYTES-1)-1:0]   shreg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         idx   <= '0;
         shreg <= '0;
      end else if (accept) begin
         for (int i = 0; i < RECORD_BYTES - 1; i++) begin
            if (idx == IDX_W'(i)) shreg[i*8 +: 8] <= in_data;
         end
         idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
   end

   assign record_full          = accept && (idx == LAST_IDX);
   assign {rec_data, rec_addr} = {in_data, shreg};

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// config_loader: turns a byte stream of 8-byte records into timed writes on the shared
// tile configuration bus, parking the bus on IDLE_ADDR between records.
module config_loader
   import cfg_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter int unsigned GAP_CYCLES  = 1,
   parameter logic [31:0] IDLE_ADDR   = IDLE_ADDR_DEF,
   parameter logic [31:0] END_ADDR    = END_ADDR_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] record_count
);

   state_t      state;
   logic        accept;
   logic        load_start;
   logic        record_full;
   logic        hold_last;
   logic        gap_last;
   logic [31:0] rec_addr;
   logic [31:0] rec_data;

   assign accept     = in_valid & in_ready;
   assign load_start = start && (state == ST_IDLE || state == ST_DONE);

   config_record_assembler u_assembler (
      .clk         (clk),
      .reset       (reset),
      .clear       (load_start),
      .accept      (accept),
      .in_data     (in_data),
      .rec_addr    (rec_addr),
      .rec_data    (rec_data),
      .record_full (record_full)
   );

   // Counters only exist when the phase lasts more than one cycle.
   generate
      if (HOLD_CYCLES > 1) begin : g_hold_cnt
         localparam int HW = $clog2(HOLD_CYCLES);
         logic [HW-1:0] hold_cnt;
         always_ff @(posedge clk) begin
            if (reset || state != ST_ISSUE) hold_cnt <= '0;
            else                            hold_cnt <= hold_cnt + 1'b1;
         end
         assign hold_last = (hold_cnt == HW'(HOLD_CYCLES - 1));
      end else begin : g_hold_none
         assign hold_last = 1'b1;
      end
   endgenerate

   generate
      if (GAP_CYCLES > 1) begin : g_gap_cnt
         localparam int GW = $clog2(GAP_CYCLES);
         logic [GW-1:0] gap_cnt;
         always_ff @(posedge clk) begin
            if (reset || state != ST_GAP) gap_cnt <= '0;
            else                          gap_cnt <= gap_cnt + 1'b1;
         end
         assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));
      end else begin : g_gap_none
         assign gap_last = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         config_addr  <= IDLE_ADDR;
         config_data  <= '0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         record_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (load_start) begin
                  state        <= ST_ASSEMBLE;
                  in_ready     <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  record_count <= '0;
               end else if (in_valid) begin
                  error <= 1'b1;
               end
            end
            ST_ASSEMBLE: begin
               if (record_full) begin
                  in_ready <= 1'b0;
                  // The terminator record is consumed but never placed on the bus.
                  if (rec_addr == END_ADDR) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state       <= ST_ISSUE;
                     config_addr <= rec_addr;
                     config_data <= rec_data;
                     if (record_count != 16'hFFFF) record_count <= record_count + 16'd1;
                  end
               end
            end
            ST_ISSUE: begin
               if (hold_last) begin
                  config_addr <= IDLE_ADDR;
                  config_data <= '0;
                  if (GAP_CYCLES == 0) begin
                     state    <= ST_ASSEMBLE;
                     in_ready <= 1'b1;
                  end else begin
                     state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_last) begin
                  state    <= ST_ASSEMBLE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// tb_config_loader: scoreboard bench for config_loader, including a 2x2 tile array model.
module tb_config_loader;

   localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;
   localparam logic [31:0] END_A  = 32'hFFFF_FFFE;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start3;
   logic        sel;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        valid_a, valid_b, rdy;

   logic        in_ready, busy, done, error;
   logic [31:0] config_addr, config_data;
   logic [15:0] record_count;
   logic        in_ready3, busy3, done3, error3;
   logic [31:0] addr3, data3;
   logic [15:0] count3;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hold_len = 0;
   logic [63:0] exp_q[$];
   int          starts[$];
   logic [31:0] tile_cfg [4][4];

   always #5 clk = ~clk;

   assign valid_a = in_valid & ~sel;
   assign valid_b = in_valid & sel;
   assign rdy     = sel ? in_ready3 : in_ready;

   config_loader #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(valid_a),
      .in_ready(in_ready), .config_addr(config_addr), .config_data(config_data),
      .busy(busy), .done(done), .error(error), .record_count(record_count)
   );

   config_loader #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .in_data(in_data), .in_valid(valid_b),
      .in_ready(in_ready3), .config_addr(addr3), .config_data(data3),
      .busy(busy3), .done(done3), .error(error3), .record_count(count3)
   );

   // Tile array model: tiles 0..3, blocks compute(4)/cb1(5)/cb0(6)/sb(7).
   always @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < 4; t++)
            for (int b = 0; b < 4; b++) tile_cfg[t][b] <= '0;
      end else if (config_addr[15:0] < 16'd4 && config_addr[31:16] >= 16'd4 && config_addr[31:16] <= 16'd7) begin
         tile_cfg[config_addr[1:0]][config_addr[17:16]] <= config_data;
      end
   end

   // Monitor: pops an expected record whenever a new one appears on the bus.
   always @(negedge clk) begin
      logic [63:0] e;
      cyc++;
      if (config_addr != IDLE_A) begin
         if (hold_len == 0) begin
            starts.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_record: got addr=%h data=%h, required no record", config_addr, config_data);
            end else begin
               e = exp_q.pop_front();
               if ({config_addr, config_data} !== e) begin
                  bad++;
                  $display("FAIL record: got addr=%h data=%h, required addr=%h data=%h",
                           config_addr, config_data, e[63:32], e[31:0]);
               end
            end
         end
         hold_len++;
      end else begin
         if (hold_len != 0) begin
            total++;
            if (hold_len != 1) begin
               bad++;
               $display("FAIL hold_len: got %0d, required 1", hold_len);
            end
         end
         hold_len = 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input bit which);
      @(negedge clk);
      if (which) start3 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0; start3 = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int guard;
      repeat (stall) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      guard    = 0;
      while (!rdy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         total++; bad++;
         $display("FAIL handshake_timeout: got no in_ready in %0d cycles, required ready", guard);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_record(input logic [31:0] a, input logic [31:0] d, input bit expect_issue, input int max_stall);
      logic [63:0] rec;
      rec = {d, a};
      if (expect_issue) exp_q.push_back({a, d});
      for (int i = 0; i < 8; i++)
         send_byte(rec[i*8 +: 8], (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0);
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || config_addr != IDLE_A) && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (g >= 300) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d pending records, required 0", exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000 ns, required finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; start3 = 1'b0; sel = 1'b0;
      in_data = 8'h00; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // 1: reset state after idling
      repeat (10) @(negedge clk);
      check("reset_addr", 64'(config_addr), 64'hFFFF_FFFF);
      check("reset_data", 64'(config_data), 64'h0);
      check("reset_ready", 64'(in_ready), 64'h0);
      check("reset_flags", {61'h0, busy, done, error}, 64'h0);
      check("reset_count", 64'(record_count), 64'h0);

      // 2: single record
      pulse_start(1'b0);
      check("start_ready", 64'(in_ready), 64'h1);
      send_record(32'h0004_0005, 32'h0000_0003, 1'b1, 0);
      wait_drain();
      check("t2_count", 64'(record_count), 64'd1);
      check("t2_busy", 64'(busy), 64'h1);

      // 3: back-to-back records then terminator
      starts.delete();
      send_record(32'h0007_0010, 32'hDEAD_BEEF, 1'b1, 0);
      send_record(32'h0005_0011, 32'h0102_0304, 1'b1, 0);
      send_record(32'h0006_0012, 32'hA5A5_5A5A, 1'b1, 0);
      send_record(END_A, 32'h0000_0000, 1'b0, 0);
      wait_drain();
      check("t3_done", 64'(done), 64'h1);
      check("t3_busy", 64'(busy), 64'h0);
      check("t3_ready", 64'(in_ready), 64'h0);
      check("t3_error", 64'(error), 64'h0);
      check("t3_count", 64'(record_count), 64'd4);
      if (starts.size() >= 3) begin
         check("t3_spacing1", 64'(starts[1] - starts[0]), 64'd10);
         check("t3_spacing2", 64'(starts[2] - starts[1]), 64'd10);
      end else begin
         total++; bad++;
         $display("FAIL t3_starts: got %0d records, required 3", starts.size());
      end

      // byte offered while DONE is refused and flags error
      in_data = 8'hAA; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("err_set", 64'(error), 64'h1);
      check("err_done_kept", 64'(done), 64'h1);
      pulse_start(1'b0);
      check("restart_flags", {61'h0, busy, done, error}, 64'h4);
      check("restart_count", 64'(record_count), 64'h0);

      // 4: stalled partial record, mid-record reset, then fresh stalled record
      send_byte(8'h11, 2);
      send_byte(8'h22, 1);
      send_byte(8'h33, 3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_reset_addr", 64'(config_addr), 64'hFFFF_FFFF);
      check("mid_reset_ready", 64'(in_ready), 64'h0);
      check("mid_reset_busy", 64'(busy), 64'h0);
      reset = 1'b0;
      pulse_start(1'b0);
      send_record(32'h0004_0009, 32'h7654_3210, 1'b1, 3);
      wait_drain();
      check("t4_count", 64'(record_count), 64'd1);
      check("t4_error", 64'(error), 64'h0);

      // 5: HOLD_CYCLES=3, GAP_CYCLES=0 instance
      sel = 1'b1;
      pulse_start(1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'(32'h0007_0002 >> (8*i)), 0);
      for (int i = 0; i < 4; i++) send_byte(8'(32'h1234_5678 >> (8*i)), 0);
      check("h3_c1", {addr3, data3}, 64'h0007_0002_1234_5678);
      check("h3_c1_ready", 64'(in_ready3), 64'h0);
      @(negedge clk);
      check("h3_c2", {addr3, data3}, 64'h0007_0002_1234_5678);
      @(negedge clk);
      check("h3_c3", {addr3, data3}, 64'h0007_0002_1234_5678);
      @(negedge clk);
      check("h3_parked", {addr3, data3}, 64'hFFFF_FFFF_0000_0000);
      check("h3_ready", 64'(in_ready3), 64'h1);
      check("h3_status", {count3, 13'h0, busy3, done3, error3}, {16'd1, 13'h0, 3'b100});
      sel = 1'b0;

      // 6: 2x2 tile array load
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pulse_start(1'b0);
      for (int t = 0; t < 4; t++)
         for (int b = 4; b < 8; b++)
            send_record({16'(b), 16'(t)}, {16'hC0DE, 8'(t), 8'(b)}, 1'b1, 0);
      send_record(END_A, 32'h0, 1'b0, 1);
      wait_drain();
      check("t6_done", 64'(done), 64'h1);
      check("t6_count", 64'(record_count), 64'd16);
      for (int t = 0; t < 4; t++)
         for (int b = 0; b < 4; b++)
            check($sformatf("tile%0d_blk%0d", t, b + 4), 64'(tile_cfg[t][b]),
                  {32'h0, 16'hC0DE, 8'(t), 8'(b + 4)});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
